// File: rtl/kernel_buffer_pp.sv
// Ping-pong kernel buffer: two banks of DEPTH words; one bank fills while the other
// is replayed reuse_count times, with s_last framing checked against the word count.
`timescale 1ns/1ps
module kernel_buffer_pp #(
   parameter int DATA_WIDTH = 16,
   parameter int UNITS      = 10,
   parameter int DEPTH      = 9,
   parameter int REUSE_W    = 8
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [DATA_WIDTH*UNITS-1:0] s_data,
   input  logic                        s_last,
   input  logic [REUSE_W-1:0]          reuse_count,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [DATA_WIDTH*UNITS-1:0] m_data,
   output logic                        m_last,
   output logic                        err
);

   // Handshake: a word moves on a side exactly in a cycle where valid and ready are
   // both high at the rising edge; ready/valid here depend only on registered state.

   localparam int W  = DATA_WIDTH * UNITS;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   logic [W-1:0]       r_mem [2][DEPTH];
   logic [1:0]         r_full;
   logic               r_wr_bank;
   logic               r_rd_bank;
   logic [AW-1:0]      r_wr_addr;
   logic [AW-1:0]      r_rd_addr;
   logic [REUSE_W-1:0] r_pass_cnt;
   logic [REUSE_W-1:0] r_pass_target;
   logic               r_err;

   logic               w_wr;
   logic               w_wr_end;
   logic               w_wr_done;
   logic               w_rd_xfer;
   logic               w_rd_wrap;
   logic               w_first_xfer;
   logic [REUSE_W-1:0] w_reuse_eff;
   logic [REUSE_W:0]   w_pass_inc;
   logic               w_release;

   assign s_ready = ~r_full[r_wr_bank];
   assign m_valid = r_full[r_rd_bank];
   assign m_data  = r_mem[r_rd_bank][r_rd_addr];
   assign m_last  = m_valid & (r_rd_addr == LAST_ADDR);
   assign err     = r_err;

   assign w_wr      = s_valid & s_ready;
   assign w_wr_end  = (r_wr_addr == LAST_ADDR);
   assign w_wr_done = w_wr & w_wr_end;

   assign w_rd_xfer    = m_valid & m_ready;
   assign w_rd_wrap    = w_rd_xfer & (r_rd_addr == LAST_ADDR);
   assign w_first_xfer = (r_rd_addr == '0) && (r_pass_cnt == '0);
   assign w_reuse_eff  = (reuse_count == '0) ? REUSE_W'(1) : reuse_count;
   assign w_pass_inc   = {1'b0, r_pass_cnt} + 1'b1;
   // The target is latched on the first transfer, which can never also be the wrap
   // because DEPTH >= 2, so the wrap always compares against the latched value.
   assign w_release    = w_rd_wrap & (w_pass_inc == {1'b0, r_pass_target});

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
               r_mem[b][a] <= '0;
            end
         end
      end else if (w_wr) begin
         r_mem[r_wr_bank][r_wr_addr] <= s_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_bank <= 1'b0;
         r_wr_addr <= '0;
         r_err     <= 1'b0;
      end else if (w_wr) begin
         if (w_wr_end) begin
            r_wr_addr <= '0;
            r_wr_bank <= ~r_wr_bank;
         end else begin
            r_wr_addr <= r_wr_addr + 1'b1;
         end
         if (s_last ^ w_wr_end) begin
            r_err <= 1'b1;
         end
      end
   end

   // Release and fill never target the same bank in one cycle: a full bank refuses writes.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_full <= 2'b00;
      end else begin
         if (w_release && !r_rd_bank) r_full[0] <= 1'b0;
         if (w_release &&  r_rd_bank) r_full[1] <= 1'b0;
         if (w_wr_done && !r_wr_bank) r_full[0] <= 1'b1;
         if (w_wr_done &&  r_wr_bank) r_full[1] <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rd_bank     <= 1'b0;
         r_rd_addr     <= '0;
         r_pass_cnt    <= '0;
         r_pass_target <= '0;
      end else if (w_rd_xfer) begin
         if (w_first_xfer) begin
            r_pass_target <= w_reuse_eff;
         end
         if (w_rd_wrap) begin
            r_rd_addr <= '0;
            if (w_release) begin
               r_pass_cnt <= '0;
               r_rd_bank  <= ~r_rd_bank;
            end else begin
               r_pass_cnt <= w_pass_inc[REUSE_W-1:0];
            end
         end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_kernel_buffer_pp.sv
// Directed bench for kernel_buffer_pp (DEPTH=9, UNITS=2): fill/replay, ping-pong
// back-pressure, framing error, reuse sampling and mid-operation reset.
`timescale 1ns/1ps
module tb_kernel_buffer_pp;

   localparam int DW = 16;
   localparam int UN = 2;
   localparam int DP = 9;
   localparam int RW = 8;
   localparam int W  = DW * UN;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [W-1:0]  s_data = '0;
   logic          s_last = 1'b0;
   logic [RW-1:0] reuse_count = '0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [W-1:0]  m_data;
   logic          m_last;
   logic          err;

   int total = 0;
   int bad   = 0;

   kernel_buffer_pp #(.DATA_WIDTH(DW), .UNITS(UN), .DEPTH(DP), .REUSE_W(RW)) dut (
      .clk(clk), .rstn(rstn),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .reuse_count(reuse_count),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .err(err)
   );

   always #5 clk = ~clk;

   // Each unit carries a distinct value so unit swaps and slicing errors show up.
   function automatic logic [W-1:0] word(input int v);
      logic [15:0] lo;
      logic [15:0] hi;
      lo = 16'(v);
      hi = 16'(v + 256);
      return {hi, lo};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic reset_and_check();
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("rst_s_ready", 64'(s_ready), 64'd1);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_last",  64'(m_last),  64'd0);
      check("rst_m_data",  64'(m_data),  64'd0);
      check("rst_err",     64'(err),     64'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   // Called at a negedge; returns at the negedge after the word is accepted.
   task automatic write_word(input int v, input logic last);
      int n;
      s_valid = 1'b1;
      s_data  = word(v);
      s_last  = last;
      n = 0;
      while (!s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) check("wr_timeout", 64'(s_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic write_set(input int base, input int last_pos);
      for (int i = 0; i < DP; i++) write_word(base + i, (i == last_pos));
   endtask

   // Called at a negedge; checks the presented word, then consumes it.
   task automatic read_word(input string tag, input int v, input logic last);
      check({tag, "_valid"}, 64'(m_valid), 64'd1);
      check({tag, "_data"},  64'(m_data),  64'(word(v)));
      check({tag, "_last"},  64'(m_last),  64'(last));
      m_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      m_ready = 1'b0;
   endtask

   task automatic read_pass(input string tag, input int base);
      for (int i = 0; i < DP; i++) read_word(tag, base + i, (i == DP - 1));
   endtask

   initial begin
      reset_and_check();

      // Fill 1..9, then three passes with the consumer always ready.
      reuse_count = 8'd3;
      for (int i = 1; i <= 8; i++) write_word(i, 1'b0);
      check("fill_pre_valid", 64'(m_valid), 64'd0);
      write_word(9, 1'b1);
      check("fill_valid", 64'(m_valid), 64'd1);
      check("fill_data",  64'(m_data),  64'(word(1)));
      check("fill_err",   64'(err),     64'd0);
      for (int p = 0; p < 3; p++) read_pass("reuse3", 1);
      check("reuse3_done", 64'(m_valid), 64'd0);

      // Two sets back-to-back with no reads: writer stalls once both banks are full.
      reuse_count = 8'd1;
      write_set(1, DP - 1);
      write_set(11, DP - 1);
      check("pp_stall_ready", 64'(s_ready), 64'd0);
      check("pp_valid",       64'(m_valid), 64'd1);
      read_pass("pp_a", 1);
      check("pp_ready_back", 64'(s_ready), 64'd1);
      check("pp_b_first",    64'(m_data),  64'(word(11)));
      read_pass("pp_b", 11);
      check("pp_empty", 64'(m_valid), 64'd0);
      check("pp_err",   64'(err),     64'd0);

      // Early s_last on word 5: sticky error, bank still completes at word 9.
      for (int i = 1; i <= 4; i++) write_word(i, 1'b0);
      check("frm_err_before", 64'(err), 64'd0);
      write_word(5, 1'b1);
      check("frm_err_set", 64'(err), 64'd1);
      for (int i = 6; i <= 8; i++) write_word(i, 1'b0);
      check("frm_not_full", 64'(m_valid), 64'd0);
      write_word(9, 1'b0);
      check("frm_full",      64'(m_valid), 64'd1);
      check("frm_err_stays", 64'(err),     64'd1);
      read_pass("frm", 1);
      check("frm_err_sticky", 64'(err), 64'd1);
      reset_and_check();

      // reuse_count=0 behaves as a single pass.
      reuse_count = 8'd0;
      write_set(21, DP - 1);
      read_pass("reuse0", 21);
      check("reuse0_done", 64'(m_valid), 64'd0);

      // Changing reuse_count mid-pass does not affect the set already being read.
      reuse_count = 8'd2;
      write_set(31, DP - 1);
      read_word("midchg", 31, 1'b0);
      read_word("midchg", 32, 1'b0);
      reuse_count = 8'd5;
      for (int i = 2; i < DP; i++) read_word("midchg", 31 + i, (i == DP - 1));
      read_pass("midchg2", 31);
      check("midchg_done", 64'(m_valid), 64'd0);

      // Reset while one bank is being read and the other is partially written.
      reuse_count = 8'd1;
      write_set(41, DP - 1);
      for (int i = 0; i < 3; i++) read_word("prerst", 41 + i, 1'b0);
      for (int i = 0; i < 4; i++) write_word(61 + i, 1'b0);
      check("prerst_valid", 64'(m_valid), 64'd1);
      reset_and_check();
      write_set(51, DP - 1);
      check("postrst_data", 64'(m_data), 64'(word(51)));
      read_pass("postrst", 51);
      check("postrst_done",  64'(m_valid), 64'd0);
      check("postrst_ready", 64'(s_ready), 64'd1);
      check("postrst_err",   64'(err),     64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
